// File: rtl/dma_buffer_core.sv
// dma_buffer_core: datapath core of the DMA controller.
// Holds a show-ahead data FIFO with last-slot replay, the transfer-length
// and start-address registers, and the address/transfer counter.
// All enables and clears come from the external DMA FSM.
// Optional build macro: DMA_BUFFER_ERR_EN adds a sticky 'err' output,
// set by a push while full or a pop while empty.
module dma_buffer_core #(
  parameter int DATA_LEN        = 8,
  parameter int ADD_LEN         = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_DIV_FACTOR = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_en,
  input  logic                  fifo_wr_rd,
  input  logic                  fifo_clr,
  input  logic                  fifo_old_add_flag,
  input  logic [DATA_LEN-1:0]   fifo_in,
  output logic [DATA_LEN-1:0]   fifo_out,
  output logic                  full,
  output logic                  empty,
  output logic                  empty_partial,
  input  logic [FIFO_DEPTH:0]   words_in,
  input  logic                  words_en,
  input  logic                  words_clr,
  input  logic [ADD_LEN-1:0]    addr_in,
  input  logic                  addr_en,
  input  logic                  addr_clr,
  input  logic                  cnt_en,
  input  logic                  cnt_load,
  input  logic                  cnt_clr,
  output logic [FIFO_DEPTH:0]   count,
  output logic                  end_cnt,
  output logic [ADD_LEN-1:0]    address,
  output logic                  cnt_done
`ifdef DMA_BUFFER_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int PTR_W   = FIFO_DEPTH + 1;
  localparam int ENTRIES = 1 << FIFO_DEPTH;
  localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(ENTRIES);
  localparam logic [PTR_W-1:0] PART_OCC = PTR_W'(ENTRIES >> FIFO_DIV_FACTOR);

  logic [DATA_LEN-1:0]   mem_q [ENTRIES];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      words_q, words_d;
  logic [ADD_LEN-1:0]    addr_q, addr_d;
  logic [PTR_W-1:0]      cnt_q, cnt_d;

  logic [PTR_W-1:0]      occ;
  logic [PTR_W-1:0]      wr_prev, rd_prev;
  logic                  push_ok, pop_ok, replay_wr, mem_we;
  logic [FIFO_DEPTH-1:0] mem_waddr, mem_raddr;

  // FIFO status: occupancy from the wrap-bit pointers.
  assign occ           = wr_ptr_q - rd_ptr_q;
  assign full          = (occ == FULL_OCC);
  assign empty         = (occ == '0);
  assign empty_partial = (occ <= PART_OCC);

  assign wr_prev   = wr_ptr_q - PTR_W'(1);
  assign rd_prev   = rd_ptr_q - PTR_W'(1);
  assign push_ok   = fifo_en & fifo_wr_rd & ~fifo_old_add_flag & ~full;
  assign pop_ok    = fifo_en & ~fifo_wr_rd & ~fifo_old_add_flag & ~empty;
  // Replay-write patches the most recently pushed slot; nothing to patch when empty.
  assign replay_wr = fifo_old_add_flag & fifo_wr_rd & ~empty;
  assign mem_we    = ~fifo_clr & (push_ok | replay_wr);
  assign mem_waddr = replay_wr ? wr_prev[FIFO_DEPTH-1:0] : wr_ptr_q[FIFO_DEPTH-1:0];
  // Replay-read shows the slot just popped instead of the current head.
  assign mem_raddr = (fifo_old_add_flag & ~fifo_wr_rd) ? rd_prev[FIFO_DEPTH-1:0]
                                                       : rd_ptr_q[FIFO_DEPTH-1:0];
  assign fifo_out  = mem_q[mem_raddr];

  // Counter-derived outputs.
  assign count    = cnt_q;
  assign end_cnt  = &cnt_q;
  assign address  = addr_q + ADD_LEN'(cnt_q);
  assign cnt_done = (cnt_q == words_q);

  // Next-state for pointers, registers and counter; clears always win.
  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    words_d  = words_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;

    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (words_clr)     words_d = '0;
    else if (words_en) words_d = words_in;

    if (addr_clr)      addr_d = '0;
    else if (addr_en)  addr_d = addr_in;

    if (cnt_clr)                  cnt_d = '0;
    else if (cnt_en && cnt_load)  cnt_d = PTR_W'(1);
    else if (cnt_en)              cnt_d = cnt_q + PTR_W'(1);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      words_q  <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage: single write port, cleared by reset but kept across fifo_clr.
  always_ff @(posedge clk) begin
    // NOTE: the storage is reset because fifo_out must read 0 after reset;
    // this rules out a plain RAM macro for the array.
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= fifo_in;
    end
  end

`ifdef DMA_BUFFER_ERR_EN
  logic err_q, err_d;

  // Sticky error: set on illegal push/pop, cleared only by fifo_clr or reset.
  always_comb begin
    err_d = err_q;
    if (fifo_clr) err_d = 1'b0;
    else if (fifo_en && !fifo_old_add_flag &&
             ((fifo_wr_rd && full) || (!fifo_wr_rd && empty))) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_dma_buffer_core.sv
// tb_dma_buffer_core: self-checking bench for dma_buffer_core.
// Popped FIFO data is checked by a monitor against a scoreboard queue filled
// by the stimulus; status, counter and address outputs are checked directly.
module tb_dma_buffer_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_en = 1'b0, fifo_wr_rd = 1'b0, fifo_clr = 1'b0, fifo_old_add_flag = 1'b0;
  logic [7:0] fifo_in = '0;
  logic [7:0] fifo_out;
  logic       full, empty, empty_partial;
  logic [4:0] words_in = '0;
  logic       words_en = 1'b0, words_clr = 1'b0;
  logic [7:0] addr_in = '0;
  logic       addr_en = 1'b0, addr_clr = 1'b0;
  logic       cnt_en = 1'b0, cnt_load = 1'b0, cnt_clr = 1'b0;
  logic [4:0] count;
  logic       end_cnt;
  logic [7:0] address;
  logic       cnt_done;
`ifdef DMA_BUFFER_ERR_EN
  logic       err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  dma_buffer_core dut (
    .clk(clk), .rst(rst),
    .fifo_en(fifo_en), .fifo_wr_rd(fifo_wr_rd), .fifo_clr(fifo_clr),
    .fifo_old_add_flag(fifo_old_add_flag), .fifo_in(fifo_in), .fifo_out(fifo_out),
    .full(full), .empty(empty), .empty_partial(empty_partial),
    .words_in(words_in), .words_en(words_en), .words_clr(words_clr),
    .addr_in(addr_in), .addr_en(addr_en), .addr_clr(addr_clr),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_clr(cnt_clr),
    .count(count), .end_cnt(end_cnt), .address(address), .cnt_done(cnt_done)
`ifdef DMA_BUFFER_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; inputs set afterwards apply at the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"},    empty, 1);
    check({tag, "_full"},     full, 0);
    check({tag, "_epart"},    empty_partial, 1);
    check({tag, "_count"},    count, 0);
    check({tag, "_address"},  address, 0);
    check({tag, "_cnt_done"}, cnt_done, 1);
    check({tag, "_end_cnt"},  end_cnt, 0);
    check({tag, "_fifo_out"}, fifo_out, 0);
`ifdef DMA_BUFFER_ERR_EN
    check({tag, "_err"},      err, 0);
`endif
  endtask

  // Monitor: on every accepted pop the head word is compared with the scoreboard.
  always @(negedge clk) begin
    if (rst && fifo_en && !fifo_wr_rd && !fifo_old_add_flag && !empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no pop at %0t", fifo_out, $time);
      end else begin
        check("pop_data", fifo_out, exp_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    check_reset_state("reset");

    // Address = start + count, wrapping at 8 bits; counter wraps at 32
    addr_in = 8'hF0; addr_en = 1'b1;
    cyc();
    addr_en = 1'b0;
    check("addr_load", address, 8'hF0);
    cnt_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      cyc();
      check("cnt_run_count", count, i % 32);
      check("cnt_run_addr", address, (8'hF0 + (i % 32)) & 8'hFF);
      check("cnt_run_end", end_cnt, (i % 32) == 31);
    end
    cnt_en = 1'b0;
    // Clear beats load on the address register
    addr_in = 8'h33; addr_en = 1'b1; addr_clr = 1'b1;
    cyc();
    addr_en = 1'b0; addr_clr = 1'b0;
    check("addr_clr_wins", address, 8'h00);

    // Fill the FIFO, then an ignored 17th push
    fifo_en = 1'b1; fifo_wr_rd = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      fifo_in = 8'(i);
      cyc();
      check("fill_full", full, i == 16);
      check("fill_empty", empty, 0);
      check("fill_epart", empty_partial, i <= 2);
    end
    fifo_in = 8'h99;
    cyc();
    check("push_full_ignored", full, 1);
    check("head_after_fill", fifo_out, 8'h01);

    // Drain: data goes through the scoreboard
    fifo_wr_rd = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(8'(i));
      cyc();
      check("drain_epart", empty_partial, (16 - i) <= 2);
      check("drain_empty", empty, i == 16);
      check("drain_full", full, 0);
    end
    fifo_en = 1'b0;

    // Replay-write overwrites the last pushed slot (slot 0 after wrap)
    fifo_en = 1'b1; fifo_wr_rd = 1'b1; fifo_in = 8'hAA;
    cyc();
    fifo_en = 1'b0; fifo_old_add_flag = 1'b1; fifo_in = 8'h55;
    cyc();
    fifo_old_add_flag = 1'b0;
    check("replay_empty", empty, 0);
    check("replay_epart", empty_partial, 1);
    check("replay_head", fifo_out, 8'h55);
    fifo_en = 1'b1; fifo_wr_rd = 1'b0;
    exp_q.push_back(8'h55);
    cyc();
    fifo_en = 1'b0;
    check("replay_pop_empty", empty, 1);
    // Replay-read shows the slot just popped
    fifo_old_add_flag = 1'b1;
    #1;
    check("replay_read", fifo_out, 8'h55);
    fifo_old_add_flag = 1'b0;

    // fifo_clr beats a push; storage is kept
    fifo_en = 1'b1; fifo_wr_rd = 1'b1; fifo_in = 8'h77;
    cyc();
    fifo_in = 8'h88; fifo_clr = 1'b1;
    cyc();
    fifo_en = 1'b0; fifo_clr = 1'b0;
    check("clr_empty", empty, 1);
    check("clr_storage_kept", fifo_out, 8'h55);

    // Words register, load-with-1, cnt_done
    words_in = 5'd5; words_en = 1'b1;
    cyc();
    words_en = 1'b0;
    check("words_cnt_done_off", cnt_done, 0);
    cnt_en = 1'b1; cnt_load = 1'b1;
    cyc();
    cnt_load = 1'b0;
    check("cnt_load_one", count, 1);
    check("cnt_done_at1", cnt_done, 0);
    for (int i = 2; i <= 6; i++) begin
      cyc();
      check("cnt_seq", count, i);
      check("cnt_done_seq", cnt_done, i == 5);
    end
    cnt_en = 1'b0; cnt_load = 1'b1;
    cyc();
    cnt_load = 1'b0;
    check("cnt_load_no_en", count, 6);
    cnt_clr = 1'b1; cnt_en = 1'b1;
    cyc();
    cnt_clr = 1'b0; cnt_en = 1'b0;
    check("cnt_clr_wins", count, 0);
    check("cnt_done_words5", cnt_done, 0);
    words_in = 5'h1F; words_en = 1'b1; words_clr = 1'b1;
    cyc();
    words_en = 1'b0; words_clr = 1'b0;
    check("words_clr_wins", cnt_done, 1);

    // Pop on empty: ignored, sticky error when enabled
    fifo_en = 1'b1; fifo_wr_rd = 1'b0;
    cyc();
    fifo_en = 1'b0;
    check("pop_empty_ignored", empty, 1);
`ifdef DMA_BUFFER_ERR_EN
    check("err_set", err, 1);
    cyc();
    check("err_held", err, 1);
    fifo_clr = 1'b1;
    cyc();
    fifo_clr = 1'b0;
    check("err_cleared", err, 0);
`endif

    // Reset in the middle of a burst
    addr_in = 8'h40; addr_en = 1'b1;
    cyc();
    addr_en = 1'b0;
    words_in = 5'd3; words_en = 1'b1; cnt_en = 1'b1;
    fifo_en = 1'b1; fifo_wr_rd = 1'b1; fifo_in = 8'h3C;
    cyc(); cyc(); cyc();
    check("burst_count", count, 3);
    check("burst_address", address, 8'h43);
    check("burst_head", fifo_out, 8'h3C);
    check("burst_epart", empty_partial, 0);
    rst = 1'b0;
    cyc();
    check_reset_state("midrst");
    rst = 1'b1;
    words_en = 1'b0; cnt_en = 1'b0; fifo_en = 1'b0; fifo_wr_rd = 1'b0;
    cyc();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
